// File: rtl/ahb_seg7_display_pkg.sv
// ahb_seg7_display_pkg
// Shared constants for the 7-segment display slave. It holds the register
// offsets, the CTRL bit positions and the AHB-Lite HTRANS/HSIZE encodings
// that every slave on this decoder uses. It also holds a helper that turns
// (HSIZE, HADDR[1:0]) into a byte-lane enable mask.
package ahb_seg7_display_pkg;

  // Register map (byte offsets within the slave window)
  localparam logic [2:0] SEG7_DIGITS_OFS = 3'h0;
  localparam logic [2:0] SEG7_CTRL_OFS   = 3'h4;

  // CTRL register bit positions
  localparam int SEG7_EN_BIT = 8;

  // AHB-Lite transfer types
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // AHB-Lite transfer sizes
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Byte lanes touched by a transfer of the given size at the given offset.
  // Any size wider than a halfword is treated as a full word.
  function automatic logic [3:0] ahb_lane_mask(input logic [2:0] size,
                                               input logic [1:0] ofs);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << ofs;
      HSIZE_HALF: m = ofs[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_seg7_display_hex_decode.sv
// seg7_hex_decode
// Purely combinational hex-to-7-segment decoder, active-low outputs.
// It is reusable by any display block.
// Ports:
//   value  in  4  hex digit 0..F
//   seg    out 7  cathodes a..g on [0]..[6], 0 = segment lit
module seg7_hex_decode (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/ahb_seg7_display.sv
// ahb_seg7_display
// AHB-Lite slave that drives a 4-digit multiplexed 7-segment display.
//   0x0 DIGITS[15:0] : nibble k is shown on digit k
//   0x4 CTRL         : [3:0] decimal-point enables, [8] display enable
// A refresh counter lights each digit for REFRESH_DIV cycles in turn.
// Ports:
//   HCLK, HRESETn                  clock, async active-low reset
//   HSEL, HREADY, HADDR, HTRANS,
//   HWRITE, HSIZE, HWDATA          AHB-Lite slave inputs
//   HREADYOUT, HRDATA              AHB-Lite slave outputs (zero wait)
//   SEG[6:0], DP, AN[3:0]          registered, active-low display pins
//
// Bus handshake: an address phase is accepted on any HCLK edge where
// HREADY=1. Its data phase completes on the next edge where HREADY=1. A
// write commits only on that completing edge, so a data phase stretched by
// HREADY=0 writes exactly once. This slave never inserts wait states.
module ahb_seg7_display
  import ahb_seg7_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [3:0]  AN
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Address-phase copies
  logic       rHSEL;
  logic [2:0] rHADDR;
  logic [1:0] rHTRANS;
  logic       rHWRITE;
  logic [2:0] rHSIZE;

  logic [15:0]      digits;
  logic [3:0]       dp_en;
  logic             disp_en;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic             wr_en;
  logic             sel_ctrl;
  logic [3:0]       lane;
  logic [31:0]      ctrl_rd;
  logic [3:0]       nib;
  logic [6:0]       dec_seg;
  logic             unused_bits;

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rHSEL   <= 1'b0;
      rHADDR  <= 3'h0;
      rHTRANS <= 2'b00;
      rHWRITE <= 1'b0;
      rHSIZE  <= 3'h0;
    end else if (HREADY) begin
      rHSEL   <= HSEL;
      rHADDR  <= HADDR[2:0];
      rHTRANS <= HTRANS;
      rHWRITE <= HWRITE;
      rHSIZE  <= HSIZE;
    end
  end

  // HREADY gates the commit so a stalled data phase writes only on its last cycle
  assign wr_en    = rHSEL & rHWRITE & rHTRANS[1] & HREADY;
  assign sel_ctrl = (rHADDR[2] == SEG7_CTRL_OFS[2]);
  assign lane     = ahb_lane_mask(rHSIZE, rHADDR[1:0]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      digits  <= 16'h0;
      dp_en   <= 4'h0;
      disp_en <= 1'b0;
    end else if (wr_en) begin
      if (!sel_ctrl) begin
        if (lane[0]) digits[7:0]  <= HWDATA[7:0];
        if (lane[1]) digits[15:8] <= HWDATA[15:8];
      end else begin
        if (lane[0]) dp_en   <= HWDATA[3:0];
        if (lane[1]) disp_en <= HWDATA[SEG7_EN_BIT];
      end
    end
  end

  always_comb begin
    ctrl_rd              = 32'h0;
    ctrl_rd[3:0]         = dp_en;
    ctrl_rd[SEG7_EN_BIT] = disp_en;
  end

  always_comb begin
    HRDATA = 32'h0;
    if (rHSEL && rHTRANS[1]) begin
      HRDATA = sel_ctrl ? ctrl_rd : {16'h0, digits};
    end
  end

  // Refresh scan: idx advances once per REFRESH_DIV cycles, even while blanked
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nib = digits[3:0];
    case (idx)
      2'd0: nib = digits[3:0];
      2'd1: nib = digits[7:4];
      2'd2: nib = digits[11:8];
      2'd3: nib = digits[15:12];
      default: nib = digits[3:0];
    endcase
  end

  seg7_hex_decode u_dec (
    .value (nib),
    .seg   (dec_seg)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      SEG <= 7'h7F;
      DP  <= 1'b1;
      AN  <= 4'hF;
    end else if (disp_en) begin
      SEG <= dec_seg;
      DP  <= ~dp_en[idx];
      AN  <= ~(4'b0001 << idx);
    end else begin
      SEG <= 7'h7F;
      DP  <= 1'b1;
      AN  <= 4'hF;
    end
  end

  assign unused_bits = ^{HADDR[31:3], HWDATA[31:16], rHTRANS[0], lane[3:2]};

endmodule

// File: tb/tb_ahb_seg7_display.sv
module tb_ahb_seg7_display;
  import ahb_seg7_display_pkg::*;

  localparam int DIV      = 4;
  localparam int WAIT_MAX = 4 * DIV + 4;

  // ---------------- clock / reset ----------------
  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic        HREADY  = 1'b1;
  logic [31:0] HADDR   = 32'h0;
  logic [1:0]  HTRANS  = 2'b00;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'h0;
  logic [31:0] HWDATA  = 32'h0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;

  always #5 HCLK = ~HCLK;

  ahb_seg7_display #(.REFRESH_DIV(DIV)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .SEG       (SEG),
    .DP        (DP),
    .AN        (AN)
  );

  // ---------------- reference model / scoreboard ----------------
  int          checks   = 0;
  int          errors   = 0;
  int          edge_cnt = 0;
  logic [31:0] m_digits = 32'h0;
  logic [31:0] m_ctrl   = 32'h0;
  logic [31:0] exp_q[$];

  logic        p_valid = 1'b0, p_sel = 1'b0, p_write = 1'b0, p_use_model = 1'b0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
  logic [2:0]  p_size = 3'h0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_seq  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_seq [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic       dp_seq  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic sel, input logic [31:0] a);
    if (!sel) return 32'h0;
    return a[2] ? m_ctrl : m_digits;
  endfunction

  // Byte-addressed register image, then trimmed to the implemented bits
  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] img;
    logic [3:0]  ln;
    case (sz)
      3'd0:    ln = 4'b0001 << a[1:0];
      3'd1:    ln = a[1] ? 4'b1100 : 4'b0011;
      default: ln = 4'hF;
    endcase
    img = a[2] ? m_ctrl : m_digits;
    for (int b = 0; b < 4; b++) if (ln[b]) img[8*b +: 8] = wd[8*b +: 8];
    if (a[2]) m_ctrl = img & 32'h0000_010F;
    else      m_digits = img & 32'h0000_FFFF;
  endtask

  // Pins after edge k+1 reflect registers and scan position after edge k
  function automatic logic [11:0] exp_pins(input logic [31:0] d, input logic [31:0] c, input int k);
    int         i;
    logic [3:0] n;
    logic [3:0] an;
    i = (k / DIV) % 4;
    if (!c[8]) return 12'hFFF;
    n = d[4*i +: 4];
    an = 4'hF;
    an[i] = 1'b0;
    return {hex_tab[n], ~c[i], an};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [31:0] sd, sc;
    int          sk;
    sd = m_digits;
    sc = m_ctrl;
    sk = edge_cnt;
    @(posedge HCLK);
    edge_cnt++;
    #1;
    check("pins", {20'h0, SEG, DP, AN}, {20'h0, exp_pins(sd, sc, sk)});
  endtask

  // Presents one address phase while completing the previous data phase.
  // 'stall' extra HREADY=0 cycles stretch the previous data phase first.
  task automatic xfer(input logic sel, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic use_model, input logic [31:0] exp,
                      input int stall);
    logic [31:0] want;
    for (int i = 0; i < stall; i++) begin
      HREADY = 1'b0; HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
      HADDR = 32'h4; HSIZE = 3'd2; HWDATA = 32'h0000_5555;
      step();
    end
    HREADY = 1'b1;
    HSEL   = sel;
    HTRANS = sel ? HTRANS_NONSEQ : HTRANS_IDLE;
    HWRITE = wr;
    HADDR  = a;
    HSIZE  = sz;
    HWDATA = p_wdata;
    if (!wr && !use_model) exp_q.push_back(exp);
    if (p_valid && !p_write) begin
      #1;
      if (p_use_model) want = model_read(p_sel, p_addr);
      else             want = exp_q.pop_front();
      check("hrdata", HRDATA, want);
    end
    step();
    if (p_valid && p_write && p_sel) model_write(p_addr, p_size, p_wdata);
    p_valid = 1'b1; p_sel = sel; p_write = wr; p_use_model = use_model;
    p_addr = a; p_size = sz; p_wdata = wd;
  endtask

  task automatic idle1();
    xfer(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 32'h0, 0);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0, vecs[i].exp, 0);
    idle1();
  endtask

  task automatic wait_an(input logic [3:0] want, input string name);
    int n = 0;
    while (AN !== want && n < WAIT_MAX) begin
      idle1();
      n++;
    end
    check(name, {28'h0, AN}, {28'h0, want});
  endtask

  task automatic hold_reset_then_release();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HREADY = 1'b1;
    m_digits = 32'h0; m_ctrl = 32'h0; edge_cnt = 0;
    p_valid = 1'b0; p_wdata = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  function automatic vec_t v(input logic sel, input logic wr, input logic [31:0] a,
                             input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] exp);
    vec_t t;
    t.sel = sel; t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd; t.exp = exp;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ga, gb, gc, gd;
    logic        sel, wr;
    logic [31:0] a, wd;
    logic [2:0]  sz;

    // group A: reset readback, word writes, readback
    vecs.push_back(v(1, 0, 32'h0, 3'd2, 32'h0,          32'h0));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0));
    vecs.push_back(v(1, 1, 32'h0, 3'd2, 32'h0000_1234,  32'h0));
    vecs.push_back(v(1, 1, 32'h4, 3'd2, 32'h0000_0105,  32'h0));
    vecs.push_back(v(1, 0, 32'h0, 3'd2, 32'h0,          32'h0000_1234));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0000_0105));
    ga = vecs.size();
    // group B: byte lane 1 of DIGITS
    vecs.push_back(v(1, 1, 32'h1, 3'd0, 32'h5A5A_AB5A,  32'h0));
    vecs.push_back(v(1, 0, 32'h0, 3'd2, 32'h0,          32'h0000_AB34));
    gb = vecs.size();
    // group C: halfword lanes, discarded lanes, back-to-back, unselected, disable
    vecs.push_back(v(1, 1, 32'h6, 3'd1, 32'hFFFF_0000,  32'h0));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0000_0105));
    vecs.push_back(v(1, 1, 32'h4, 3'd1, 32'h0000_01F3,  32'h0));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0000_0103));
    vecs.push_back(v(1, 1, 32'h2, 3'd1, 32'hBEEF_0000,  32'h0));
    vecs.push_back(v(1, 0, 32'h0, 3'd2, 32'h0,          32'h0000_AB34));
    vecs.push_back(v(1, 1, 32'h0, 3'd2, 32'h0000_FFFF,  32'h0));
    vecs.push_back(v(1, 0, 32'h0, 3'd2, 32'h0,          32'h0000_FFFF));
    vecs.push_back(v(0, 0, 32'h0, 3'd2, 32'h0,          32'h0));
    vecs.push_back(v(1, 1, 32'h7, 3'd0, 32'hFF00_0000,  32'h0));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0000_0103));
    vecs.push_back(v(1, 1, 32'h5, 3'd0, 32'h0000_0000,  32'h0));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0000_0003));
    gc = vecs.size();
    // group D: readback after async reset
    vecs.push_back(v(1, 0, 32'h0, 3'd2, 32'h0,          32'h0));
    vecs.push_back(v(1, 0, 32'h4, 3'd2, 32'h0,          32'h0));
    gd = vecs.size();

    // reset state
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_pins", {20'h0, SEG, DP, AN}, 32'h0000_0FFF);
    check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("reset_hrdata", HRDATA, 32'h0);
    hold_reset_then_release();

    run_table(0, ga);

    // scan order and content for 1234 with DP on digits 0 and 2
    wait_an(4'h7, "scan_sync");
    wait_an(4'hE, "scan_start");
    for (int d = 0; d < 4; d++) begin
      check("scan_an",  {28'h0, AN},  {28'h0, an_seq[d]});
      check("scan_seg", {25'h0, SEG}, {25'h0, seg_seq[d]});
      check("scan_dp",  {31'h0, DP},  {31'h0, dp_seq[d]});
      repeat (DIV) idle1();
    end

    run_table(ga, gb);
    wait_an(4'h7, "digit3_wait");
    check("digit3_A", {25'h0, SEG}, 32'h0000_0008);

    run_table(gb, gc);
    // display disabled: pins blank while the scan keeps running
    idle1();
    check("disable_blank", {20'h0, SEG, DP, AN}, 32'h0000_0FFF);
    repeat (2 * DIV) idle1();
    xfer(1, 1, 32'h5, 3'd0, 32'h0000_0100, 1'b1, 32'h0, 0);
    idle1();
    repeat (DIV) idle1();

    // stalled write data phase commits once with the final data
    xfer(1, 1, 32'h0, 3'd2, 32'h0000_C0DE, 1'b1, 32'h0, 0);
    xfer(1, 0, 32'h0, 3'd2, 32'h0,         1'b0, 32'h0000_C0DE, 3);
    idle1();

    // randomized traffic against the model
    for (int n = 0; n < 120; n++) begin
      sz = 3'($urandom_range(0, 2));
      a  = $urandom();
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      sel = ($urandom_range(0, 7) != 0);
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom();
      if (a[2]) wd[8] = ($urandom_range(0, 3) != 0);
      xfer(sel, wr, a, sz, wd, 1'b1, 32'h0,
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    idle1();

    // async reset mid-frame on digit 2
    xfer(1, 1, 32'h0, 3'd2, 32'h0000_1234, 1'b1, 32'h0, 0);
    xfer(1, 1, 32'h4, 3'd2, 32'h0000_010F, 1'b1, 32'h0, 0);
    idle1();
    wait_an(4'hB, "async_wait_idx2");
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_pins", {20'h0, SEG, DP, AN}, 32'h0000_0FFF);
    check("async_hrdata", HRDATA, 32'h0);
    hold_reset_then_release();
    run_table(gc, gd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
